rx_symbol_packer: RTL

RX_SYMBOL_PACKER -- requirements
Module: rx_symbol_packer

---
 rtl/rx_symbol_packer_pkg.sv | 22 ++
 rtl/rx_symbol_packer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/rx_symbol_packer_pkg.sv
// rtl/rx_symbol_packer_pkg.sv - shared constants, state type and width helper for the symbol packer
package rx_symbol_packer_pkg;

  localparam logic [5:0] WIDTH_8  = 6'd8;
  localparam logic [5:0] WIDTH_16 = 6'd16;
  localparam logic [5:0] WIDTH_32 = 6'd32;

  localparam logic [7:0] COM_SYM_DEFAULT = 8'hBC;
  localparam logic [7:0] SKP_SYM_DEFAULT = 8'h1C;

  localparam int ERR_THRESH = 3;

  typedef enum logic {
    UNALIGNED = 1'b0,
    ALIGNED   = 1'b1
  } pack_state_t;

  function automatic logic width_legal(input logic [5:0] w, input int max_bytes);
    return (w == WIDTH_8) || (w == WIDTH_16) || ((w == WIDTH_32) && (max_bytes == 4));
  endfunction

endpackage

// File: rtl/rx_symbol_packer.sv
// rtl/rx_symbol_packer.sv - aligns on COM, optionally drops SKP, packs 1/2/4 decoded symbols per output word
module rx_symbol_packer
  import rx_symbol_packer_pkg::*;
#(
  parameter int         MAX_BYTES = 4,
  parameter logic [7:0] COM_SYM   = COM_SYM_DEFAULT,
  parameter logic [7:0] SKP_SYM   = SKP_SYM_DEFAULT,
  parameter bit         DROP_SKP  = 1'b1
) (
  input  logic                   PCLK,
  input  logic                   Rst_n,
  input  logic                   sym_valid,
  input  logic [7:0]             sym_in,
  input  logic                   sym_k,
  input  logic [5:0]             width,
  output logic [8*MAX_BYTES-1:0] data_out,
  output logic [MAX_BYTES-1:0]   datak_out,
  output logic                   data_valid,
  output logic                   aligned,
  output logic                   align_err,
  output logic                   cfg_err
);

  localparam int IW = (MAX_BYTES > 2) ? 2 : 1;
  localparam int DW = 8 * MAX_BYTES;

  pack_state_t          state;
  logic [IW-1:0]        idx;
  logic [1:0]           err_cnt;
  logic [5:0]           width_q;
  logic [DW-1:0]        buf_data;
  logic [MAX_BYTES-1:0] buf_k;

  logic [5:0]           width_eff;
  logic                 legal;
  logic [2:0]           n_bytes;
  logic                 is_com;
  logic                 is_skp;
  logic                 misalign;
  logic                 thresh_hit;
  logic [IW-1:0]        wr_idx;
  logic                 wr_last;
  logic                 write_en;
  logic [DW-1:0]        nxt_data;
  logic [MAX_BYTES-1:0] nxt_k;

  // A new word takes its size from the live width input; mid-word the latched copy rules.
  always_comb begin
    width_eff  = (idx == '0) ? width : width_q;
    legal      = width_legal(width_eff, MAX_BYTES);
    n_bytes    = width_eff[5:3];
    is_com     = sym_k && (sym_in == COM_SYM);
    is_skp     = DROP_SKP && sym_k && (sym_in == SKP_SYM);
    misalign   = is_com && (idx != '0);
    thresh_hit = misalign && (err_cnt == 2'(ERR_THRESH - 1));
    wr_idx     = misalign ? '0 : idx;
    wr_last    = ((3'(wr_idx) + 3'd1) == n_bytes);
    write_en   = legal && sym_valid &&
                 ((state == ALIGNED) ? (!is_skp && !thresh_hit) : is_com);
    nxt_data   = (wr_idx == '0) ? '0 : buf_data;
    nxt_k      = (wr_idx == '0) ? '0 : buf_k;
    nxt_data[{wr_idx, 3'b000} +: 8] = sym_in;
    nxt_k[wr_idx]                   = sym_k;
  end

  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= UNALIGNED;
      idx        <= '0;
      err_cnt    <= '0;
      width_q    <= WIDTH_8;
      buf_data   <= '0;
      buf_k      <= '0;
      data_out   <= '0;
      datak_out  <= '0;
      data_valid <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      align_err  <= 1'b0;
      if (idx == '0) width_q <= width;
      if (!legal) begin
        state   <= UNALIGNED;
        idx     <= '0;
        err_cnt <= '0;
      end else if (sym_valid) begin
        if ((state == UNALIGNED) && is_com) begin
          state   <= ALIGNED;
          err_cnt <= '0;
        end
        if ((state == ALIGNED) && misalign) begin
          align_err <= 1'b1;
          if (thresh_hit) begin
            state   <= UNALIGNED;
            idx     <= '0;
            err_cnt <= '0;
          end else begin
            err_cnt <= err_cnt + 2'd1;
          end
        end
        if (write_en) begin
          if (wr_last) begin
            data_out   <= nxt_data;
            datak_out  <= nxt_k;
            data_valid <= 1'b1;
            idx        <= '0;
            err_cnt    <= '0;
          end else begin
            buf_data <= nxt_data;
            buf_k    <= nxt_k;
            idx      <= wr_idx + IW'(1);
          end
        end
      end
    end
  end

  assign aligned = (state == ALIGNED);
  assign cfg_err = !width_legal(width_q, MAX_BYTES);

endmodule
